// File: rtl/alu_controller.sv
// alu_controller: accepts one ALU request at a time, presents registered operands
// and select to an external combinational ALU, captures the result one cycle later,
// updates the accumulator and holds the response until the consumer takes it.
//
// Ports:
//   clk, reset             clock, asynchronous active-low reset
//   req_valid / req_ready  request handshake
//   req_op                 ALU select (000 add, 001 shl, 010 shr, 011 counter,
//                          100 and, 101 or, 110 xor, 111 no-op)
//   req_a, req_b           request operands
//   req_use_acc            take operand A from the accumulator instead of req_a
//   alu_a, alu_b, alu_sel  registered operands/select to the ALU
//   alu_result             combinational ALU result
//   rsp_valid / rsp_ready  response handshake
//   rsp_data, rsp_err      captured result, error flag for no-op
//   acc                    accumulator
//   op_count               completed responses, modulo 256
module alu_controller #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_use_acc,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic [WIDTH-1:0] acc,
  output logic [7:0]       op_count
);

  localparam int unsigned SEL_W = 3;
  localparam int unsigned CNT_W = 8;
  localparam logic [SEL_W-1:0] OP_NOP = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;

  // Request -> execute -> response sequencer; every output is a register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= OP_NOP;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      acc       <= '0;
      op_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Accumulator is sampled here; a result captured on this same edge
          // cannot exist, since captures only happen in EXEC.
          if (req_valid && req_ready) begin
            alu_a     <= req_use_acc ? acc : req_a;
            alu_b     <= req_b;
            alu_sel   <= req_op;
            req_ready <= 1'b0;
            state     <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= alu_result;
          rsp_err   <= (alu_sel == OP_NOP);
          rsp_valid <= 1'b1;
          if (alu_sel != OP_NOP) begin
            acc <= alu_result;
          end
          state <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            op_count  <= op_count + CNT_W'(1);
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
